sw_debounce_mmio: RTL and testbench

//  Switch-input peripheral upstream of the MiniLab CPU data bus.

---
 rtl/sw_debounce_mmio.sv | 137 +++++++++++++
 tb/tb_sw_debounce_mmio.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_mmio.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce_mmio
// Purpose  : Switch-input peripheral for the MiniLab CPU data bus. Raw board
//            switches pass through a two-flop synchronizer, then a per-bit
//            debouncer. The clean value and a sticky change flag are exposed
//            as two memory-mapped registers.
// Ports    : clk        - system clock, rising edge
//            RST        - synchronous active-high reset
//            SW         - raw asynchronous switch levels [NUM_SW]
//            addr       - CPU data address [16]
//            re / we    - CPU read / write strobes
//            wdata      - CPU write data [16]; only bit 0 is used (status clear)
//            rdata      - registered read data, 0 when not selected [16]
//            sw_stable  - debounced switch value [NUM_SW]
//            chg        - sticky flag, set on any sw_stable change
// Map      : BASE_ADDR   : switch data (read only, writes ignored)
//            BASE_ADDR+1 : status {15'h0, chg}; write wdata[0]=1 clears chg
// Config   : DEBOUNCE_BYPASS_EN - when defined, counters are removed and
//            sw_stable follows the synchronizer output every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sw_debounce_mmio #(
  parameter int          NUM_SW    = 10,
  parameter int          DB_CYCLES = 16,
  parameter int          CNT_W     = $clog2(DB_CYCLES),
  parameter logic [15:0] BASE_ADDR = 16'hC001
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [NUM_SW-1:0] SW,
  input  logic [15:0]       addr,
  input  logic              re,
  input  logic              we,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic [NUM_SW-1:0] sw_stable,
  output logic              chg
);

  localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;

  logic [NUM_SW-1:0] s1_q, s1_d;
  logic [NUM_SW-1:0] s2_q, s2_d;
  logic [NUM_SW-1:0] sw_stable_q, sw_stable_d;
  logic              chg_q, chg_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [15:0]       sw_ext;
  logic              stat_clr;

  // Upper write-data bits have no function in this block.
  logic unused_wdata;
  assign unused_wdata = ^wdata[15:1];

`ifndef DEBOUNCE_BYPASS_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q [NUM_SW];
  logic [CNT_W-1:0] cnt_d [NUM_SW];
`else
  localparam int unused_cnt_w = CNT_W;
`endif

  always_comb begin
    // Synchronizer: pure flop-to-flop, no logic in between.
    s1_d        = SW;
    s2_d        = s1_q;
    sw_stable_d = sw_stable_q;
`ifndef DEBOUNCE_BYPASS_EN
    cnt_d       = cnt_q;
    for (int i = 0; i < NUM_SW; i++) begin
      if (s2_q[i] == sw_stable_q[i]) begin
        // Any matching cycle restarts the window.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        sw_stable_d[i] = s2_q[i];
        cnt_d[i]       = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
`else
    sw_stable_d = s2_q;
`endif

    // Change flag: a new change on the same edge beats a software clear.
    stat_clr = we && (addr == STAT_ADDR) && wdata[0];
    chg_d    = chg_q;
    if (sw_stable_d != sw_stable_q) begin
      chg_d = 1'b1;
    end else if (stat_clr) begin
      chg_d = 1'b0;
    end

    // Read mux returns zero when unselected so it can be OR-ed onto the bus.
    // The status read uses chg_q, i.e. the value before any same-cycle clear.
    sw_ext               = '0;
    sw_ext[NUM_SW-1:0]   = sw_stable_q;
    rdata_d              = 16'h0000;
    if (re && (addr == BASE_ADDR)) begin
      rdata_d = sw_ext;
    end else if (re && (addr == STAT_ADDR)) begin
      rdata_d = {15'h0000, chg_q};
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      s1_q        <= '0;
      s2_q        <= '0;
      sw_stable_q <= '0;
      chg_q       <= 1'b0;
      rdata_q     <= 16'h0000;
`ifndef DEBOUNCE_BYPASS_EN
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= '0;
      end
`endif
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      sw_stable_q <= sw_stable_d;
      chg_q       <= chg_d;
      rdata_q     <= rdata_d;
`ifndef DEBOUNCE_BYPASS_EN
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
`endif
    end
  end

  assign sw_stable = sw_stable_q;
  assign chg       = chg_q;
  assign rdata     = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_debounce_mmio
// Purpose  : Self-checking bench for sw_debounce_mmio. A window-based model
//            (a bit flips once the last WIN synchronized samples all disagree
//            with it) predicts sw_stable, chg and rdata every cycle. Directed
//            scenarios are followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_debounce_mmio;

  localparam int NUM_SW = 10;
  localparam int DB     = 16;
`ifdef DEBOUNCE_BYPASS_EN
  localparam int WIN = 1;
`else
  localparam int WIN = DB;
`endif
  localparam int LAT = WIN + 1;   // edges from first sample to sw_stable update
  localparam logic [15:0] A_DATA = 16'hC001;
  localparam logic [15:0] A_STAT = 16'hC002;

  logic              clk = 1'b0;
  logic              RST;
  logic [NUM_SW-1:0] SW;
  logic [15:0]       addr;
  logic              re;
  logic              we;
  logic [15:0]       wdata;
  logic [15:0]       rdata;
  logic [NUM_SW-1:0] sw_stable;
  logic              chg;

  always #5 clk = ~clk;

  sw_debounce_mmio #(
    .NUM_SW   (NUM_SW),
    .DB_CYCLES(DB),
    .BASE_ADDR(A_DATA)
  ) u_dut (
    .clk      (clk),
    .RST      (RST),
    .SW       (SW),
    .addr     (addr),
    .re       (re),
    .we       (we),
    .wdata    (wdata),
    .rdata    (rdata),
    .sw_stable(sw_stable),
    .chg      (chg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [NUM_SW-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0;
  logic              m_chg = 1'b0;
  logic [15:0]       m_rdata = 16'h0000;
  logic [NUM_SW-1:0] hist[$];      // synchronized samples since last reset

  // One clock: advance model with the inputs in force, then compare outputs.
  task automatic step();
    logic [NUM_SW-1:0] nxt;
    bit                all_diff;
    @(posedge clk);
    if (RST) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_chg = 1'b0; m_rdata = 16'h0000;
      hist.delete();
    end else begin
      if (re && addr == A_DATA)      m_rdata = 16'(m_stable);
      else if (re && addr == A_STAT) m_rdata = {15'h0, m_chg};
      else                           m_rdata = 16'h0000;
      hist.push_back(m_s2);
      if (hist.size() > WIN) void'(hist.pop_front());
      nxt = m_stable;
      if (hist.size() == WIN) begin
        for (int i = 0; i < NUM_SW; i++) begin
          all_diff = 1'b1;
          foreach (hist[k]) if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) nxt[i] = ~m_stable[i];
        end
      end
      if (nxt != m_stable) m_chg = 1'b1;
      else if (we && addr == A_STAT && wdata[0]) m_chg = 1'b0;
      m_stable = nxt;
      m_s2 = m_s1;
      m_s1 = SW;
    end
    #1;
    check_val("sw_stable", 16'(sw_stable), 16'(m_stable));
    check_val("chg", 16'(chg), 16'(m_chg));
    check_val("rdata", rdata, m_rdata);
  endtask

  task automatic idle_bus();
    re = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 16'h0000;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int rises, rise_at, hit;
    logic prev;

    RST = 1'b1; SW = '0;
    idle_bus();

    // Case 1: reset then a single debounced change.
    steps(2);
    check_val("rst_stable", 16'(sw_stable), 16'h0000);
    check_val("rst_chg", 16'(chg), 16'h0000);
    check_val("rst_rdata", rdata, 16'h0000);
    RST = 1'b0; SW = 10'h2A5;
    steps(LAT);
    check_val("c1_before", 16'(sw_stable), 16'h0000);
    step();
    check_val("c1_after", 16'(sw_stable), 16'h02A5);
    check_val("c1_chg", 16'(chg), 16'h0001);

    // Return to steady zero and clear the flag.
    SW = '0;
    steps(LAT + 3);
    we = 1'b1; addr = A_STAT; wdata = 16'h0001;
    step();
    idle_bus();

    // Case 2: a 14-cycle glitch must not pass.
    SW[3] = 1'b1;
    steps(14);
    SW[3] = 1'b0;
    steps(LAT + 3);
`ifndef DEBOUNCE_BYPASS_EN
    check_val("c2_stable", 16'(sw_stable), 16'h0000);
    check_val("c2_chg", 16'(chg), 16'h0000);
`endif

    // Case 3: bouncing SW[0], then a final hold at 1.
    for (int t = 0; t < 6; t++) begin
      SW[0] = ~SW[0];
      steps(3);
    end
    SW[0] = 1'b1;
    rises = 0; rise_at = 0; prev = sw_stable[0];
    for (int k = 1; k <= LAT + 20; k++) begin
      step();
      if (sw_stable[0] && !prev) begin rises++; rise_at = k; end
      prev = sw_stable[0];
    end
`ifndef DEBOUNCE_BYPASS_EN
    check_val("c3_rises", 16'(rises), 16'd1);
    check_val("c3_rise_at", 16'(rise_at), 16'(LAT + 1));
`endif

    // Case 4: register reads.
    SW = 10'h3FF;
    steps(LAT + 3);
    re = 1'b1; addr = A_DATA;
    step();
    check_val("c4_rd_data", rdata, 16'h03FF);
    addr = 16'hC003;
    step();
    check_val("c4_rd_other", rdata, 16'h0000);
    idle_bus();
    step();
    check_val("c4_idle", rdata, 16'h0000);

    // Case 5: clear, clear colliding with a set, read during clear.
    check_val("c5_chg_pre", 16'(chg), 16'h0001);
    we = 1'b1; addr = A_STAT; wdata = 16'h0001;
    step();
    check_val("c5_cleared", 16'(chg), 16'h0000);
    idle_bus();
    SW = 10'h0F0;
    steps(LAT);
    we = 1'b1; re = 1'b1; addr = A_STAT; wdata = 16'h0001;
    step();
    check_val("c5_set_wins", 16'(chg), 16'h0001);
    check_val("c5_rd_pre0", rdata, 16'h0000);
    step();
    check_val("c5_rd_pre1", rdata, 16'h0001);
    check_val("c5_clr2", 16'(chg), 16'h0000);
    idle_bus();

    // Case 6: reset in the middle of a pending window.
    SW = 10'h155;
    steps(12);
    RST = 1'b1;
    step();
    check_val("c6_stable", 16'(sw_stable), 16'h0000);
    check_val("c6_chg", 16'(chg), 16'h0000);
    check_val("c6_rdata", rdata, 16'h0000);
    RST = 1'b0;
    hit = 0;
    for (int k = 1; k <= LAT + 5 && hit == 0; k++) begin
      step();
      if (sw_stable == 10'h155) hit = k;
    end
    check_val("c6_restart", 16'(hit), 16'(LAT + 1));

    // Randomized phase.
    for (int n = 0; n < 4000; n++) begin
      idle_bus();
      RST = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 29) == 0) SW[$urandom_range(0, NUM_SW - 1)] ^= 1'b1;
      if ($urandom_range(0, 299) == 0) SW = NUM_SW'($urandom);
      case ($urandom_range(0, 5))
        0: begin re = 1'b1; addr = A_DATA; end
        1: begin re = 1'b1; addr = A_STAT; end
        2: begin re = 1'b1; addr = 16'($urandom); end
        3: begin we = 1'b1; addr = A_STAT; wdata = 16'($urandom); end
        4: begin we = 1'b1; re = $urandom_range(0, 1) == 1; addr = A_DATA;
                 wdata = 16'($urandom); end
        default: ;
      endcase
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
